// File: rtl/mw_timer_pkg.sv
// mw_timer_pkg: shared types and constants for the microwave cook timer.
// FSM state encoding, BCD digit type and per-digit wrap limits.
package mw_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam bcd_t ONES_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit with sync clear, parallel load
// and a combinational borrow that feeds the next more-significant digit.
// Priority: clr over ld over dec.
import mw_timer_pkg::*;

module bcd_down_digit #(
    parameter bcd_t MAX = ONES_MAX
) (
    input  logic clk,
    input  logic clearn,
    input  logic clr,
    input  logic ld,
    input  bcd_t d,
    input  logic dec,
    output bcd_t q,
    output logic borrow
);

    bcd_t r_q;

    // Digit register: decrement wraps 0 -> MAX, the wrap is signalled as borrow.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
        end
    end

    assign q      = r_q;
    assign borrow = dec & (r_q == 4'd0);

endmodule

// File: rtl/mw_timer_ctrl.sv
// mw_timer_ctrl: microwave cook-timer controller. Keypad entry into mm:ss,
// one-second prescaled down-count while cooking, magnetron enable, pause/done.
// Build option: define MW_DOOR_INTERLOCK_EN to let door_closed gate start and
// force COOK->PAUSE / DONE->IDLE on door open; otherwise the door is ignored.
//
// state | meaning
// IDLE  | digits editable by keypad, waiting for start
// COOK  | magnetron on, counting down once per tick
// PAUSE | magnetron off, digits and prescaler held
// DONE  | time expired at 00:00, done asserted
import mw_timer_pkg::*;

module mw_timer_ctrl #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] keypad,
    input  logic       key_valid,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_mag_on;
    logic          r_done;

    logic w_stop, w_start, w_door;
    logic w_zero, w_last, w_key_ok;
    logic w_tick, w_clr, w_ld;
    logic w_b0, w_b1, w_b2, w_b3;

    assign w_stop  = ~stopn;
    assign w_start = ~startn;
`ifdef MW_DOOR_INTERLOCK_EN
    assign w_door  = door_closed;
`else
    assign w_door  = 1'b1;
`endif

    assign w_zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd0);
    // Only 00:01 can decrement to 00:00.
    assign w_last   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd1);
    // Shifting a sec_ones above 5 into sec_tens would make an invalid time.
    assign w_key_ok = key_valid && (keypad <= ONES_MAX) && (sec_ones <= TENS_MAX);

    assign w_tick = (r_state == ST_COOK) && !w_stop && w_door && (r_presc == PRESC_LAST);
    assign w_clr  = w_stop && ((r_state == ST_IDLE) || (r_state == ST_PAUSE));
    assign w_ld   = (r_state == ST_IDLE) && !w_stop && !w_start && w_key_ok;

    bcd_down_digit #(.MAX(ONES_MAX)) u_sec_ones (
        .clk(clk), .clearn(clearn), .clr(w_clr), .ld(w_ld), .d(keypad),
        .dec(w_tick), .q(sec_ones), .borrow(w_b0)
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_sec_tens (
        .clk(clk), .clearn(clearn), .clr(w_clr), .ld(w_ld), .d(sec_ones),
        .dec(w_b0), .q(sec_tens), .borrow(w_b1)
    );

    bcd_down_digit #(.MAX(ONES_MAX)) u_min_ones (
        .clk(clk), .clearn(clearn), .clr(w_clr), .ld(w_ld), .d(sec_tens),
        .dec(w_b1), .q(min_ones), .borrow(w_b2)
    );

    bcd_down_digit #(.MAX(ONES_MAX)) u_min_tens (
        .clk(clk), .clearn(clearn), .clr(w_clr), .ld(w_ld), .d(min_ones),
        .dec(w_b2), .q(min_tens), .borrow(w_b3)
    );

    // Control FSM with prescaler and registered magnetron/done outputs.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_mag_on <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_stop && w_start && w_door && !w_zero) begin
                        r_state  <= ST_COOK;
                        r_presc  <= '0;
                        r_mag_on <= 1'b1;
                    end
                end
                ST_COOK: begin
                    if (w_stop || !w_door) begin
                        r_state  <= ST_PAUSE;
                        r_mag_on <= 1'b0;
                    end else if (r_presc == PRESC_LAST) begin
                        r_presc <= '0;
                        if (w_last) begin
                            r_state  <= ST_DONE;
                            r_mag_on <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_start && w_door) begin
                        r_state  <= ST_COOK;
                        r_mag_on <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_stop || !w_door) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mag_on = r_mag_on;
    assign done   = r_done;
    assign state  = r_state;

endmodule

// File: tb/tb_mw_timer_ctrl.sv
// tb_mw_timer_ctrl: directed self-checking bench for mw_timer_ctrl (TICK_DIV=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mw_timer_ctrl;

    logic       clk = 1'b0;
    logic       clearn;
    logic [3:0] keypad;
    logic       key_valid;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       mag_on, done;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    mw_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .clearn(clearn), .keypad(keypad), .key_valid(key_valid),
        .startn(startn), .stopn(stopn), .door_closed(door_closed),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .mag_on(mag_on), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tm();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] k);
        keypad = k; key_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0; cyc(1); startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0; cyc(1); stopn = 1'b1;
    endtask

    initial begin
        clearn = 1'b0; keypad = 4'd0; key_valid = 1'b0;
        startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        cyc(2);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_time", tm(), 16'h0000);
        chk("rst_outs", {14'd0, mag_on, done}, 16'd0);
        clearn = 1'b1;
        cyc(1);

        // Start with 00:00 does nothing
        press_start();
        chk("start_zero", 16'(state), 16'd0);

        // Keypad entry
        key(4'd1); key(4'd3); key(4'd0);
        chk("keys_130", tm(), 16'h0130);
        key(4'd7);
        chk("key_7", tm(), 16'h1307);
        key(4'hA);
        chk("key_A", tm(), 16'h1307);
        press_stop();
        chk("idle_stop", tm(), 16'h0000);

        // sec_ones > 5 blocks further shift
        key(4'd0); key(4'd0); key(4'd7);
        key(4'd2);
        chk("key_rej", tm(), 16'h0007);
        press_stop();

        // Full cook 01:00 -> DONE
        key(4'd1); key(4'd0); key(4'd0);
        press_start();
        chk("cook_st", {14'd0, state}, 16'd1);
        chk("cook_mag", {15'd0, mag_on}, 16'd1);
        cyc(3);
        chk("pre_tick", tm(), 16'h0100);
        cyc(1);
        chk("tick1", tm(), 16'h0059);
        cyc(231);
        chk("t_0002", tm(), 16'h0002);
        cyc(1);
        chk("t_0001", tm(), 16'h0001);
        chk("t_0001_st", 16'(state), 16'd1);
        cyc(3);
        chk("t_0001b", tm(), 16'h0001);
        cyc(1);
        chk("done_time", tm(), 16'h0000);
        chk("done_flags", {12'd0, state, mag_on, done}, {12'd0, 2'd3, 1'b0, 1'b1});
        press_start();
        chk("done_ign_start", 16'(state), 16'd3);
        press_stop();
        chk("done_stop", {14'd0, state[0], done}, 16'd0);
        chk("done_stop_st", 16'(state), 16'd0);

        // Door open in COOK with prescaler=2
        key(4'd1); key(4'd0);
        press_start();
        cyc(2);
        door_closed = 1'b0;
        cyc(1);
`ifdef MW_DOOR_INTERLOCK_EN
        chk("door_pause", {12'd0, state, mag_on, 1'b0}, {12'd0, 2'd2, 1'b0, 1'b0});
        cyc(5);
        chk("door_hold", tm(), 16'h0010);
        door_closed = 1'b1;
        press_start();
        chk("resume_st", 16'(state), 16'd1);
        cyc(1);
        chk("resume_hold", tm(), 16'h0010);
        cyc(1);
        chk("resume_dec", tm(), 16'h0009);
`else
        chk("door_ign", {12'd0, state, mag_on, 1'b0}, {12'd0, 2'd1, 1'b1, 1'b0});
        chk("door_ign_t", tm(), 16'h0010);
        cyc(1);
        chk("door_ign_dec", tm(), 16'h0009);
        door_closed = 1'b1;
`endif

        // start+stop together in COOK -> PAUSE, second stop -> IDLE
        startn = 1'b0; stopn = 1'b0;
        cyc(1);
        startn = 1'b1; stopn = 1'b1;
        chk("both_pause", {12'd0, state, mag_on, 1'b0}, {12'd0, 2'd2, 1'b0, 1'b0});
        chk("both_time", tm(), 16'h0009);
        cyc(2);
        chk("pause_stay", 16'(state), 16'd2);
        press_stop();
        chk("pause_stop", 16'(state), 16'd0);
        chk("pause_clr", tm(), 16'h0000);

        // Asynchronous reset mid-cook
        key(4'd5); key(4'd4); key(4'd3);
        press_start();
        cyc(3);
        chk("pre_rst", tm(), 16'h0543);
        #2 clearn = 1'b0;
        #1;
        chk("arst_state", 16'(state), 16'd0);
        chk("arst_time", tm(), 16'h0000);
        chk("arst_outs", {14'd0, mag_on, done}, 16'd0);
        cyc(1);
        clearn = 1'b1;
        cyc(6);
        chk("post_rst", {12'd0, state, mag_on, done}, 16'd0);
        chk("post_rst_t", tm(), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
